playback_scheduler: RTL

PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

---
 rtl/playback_scheduler_pkg.sv | 48 ++++
 rtl/playback_scheduler_rr_arbiter4.sv | 35 +++
 rtl/playback_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/playback_scheduler_pkg.sv
// Shared types, default timing/table constants and small channel-index helpers
// for the four-channel playback scheduler.
package playback_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int DEF_TICK_DIV = 11;
    localparam int DEF_LEN0     = 132;
    localparam int DEF_LEN1     = 121;
    localparam int DEF_LEN2     = 88;
    localparam int DEF_LEN3     = 55;

    function automatic logic [1:0] lowest_idx(input logic [3:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        if (vec[0]) begin
            idx = 2'd0;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] idx;
        case (onehot)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/playback_scheduler_rr_arbiter4.sv
// Round-robin search of the pending vector starting after the current channel;
// the current channel itself is never offered so the caller decides whether to keep it.
module rr_arbiter4
    import playback_scheduler_pkg::*;
(
    input  logic [3:0] pend_i,
    input  logic [1:0] chan_i,
    output logic [3:0] grant_o,
    output logic       none_o
);

    logic [1:0] c1_s;
    logic [1:0] c2_s;
    logic [1:0] c3_s;

    assign c1_s = chan_i + 2'd1;
    assign c2_s = chan_i + 2'd2;
    assign c3_s = chan_i + 2'd3;

    // Priority search chan+1, chan+2, chan+3 (mod 4)
    always_comb begin
        grant_o = 4'b0000;
        none_o  = 1'b0;
        if (pend_i[c1_s]) begin
            grant_o = idx_to_onehot(c1_s);
        end else if (pend_i[c2_s]) begin
            grant_o = idx_to_onehot(c2_s);
        end else if (pend_i[c3_s]) begin
            grant_o = idx_to_onehot(c3_s);
        end else begin
            none_o = 1'b1;
        end
    end

endmodule

// File: rtl/playback_scheduler.sv
// Four-channel table playback scheduler: steps a shared ROM address once per
// sample tick and picks the next channel at each table end.
module playback_scheduler
    import playback_scheduler_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int LEN0     = DEF_LEN0,
    parameter int LEN1     = DEF_LEN1,
    parameter int LEN2     = DEF_LEN2,
    parameter int LEN3     = DEF_LEN3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       latch_mode,
    input  logic [7:0] rom0_data,
    input  logic [7:0] rom1_data,
    input  logic [7:0] rom2_data,
    input  logic [7:0] rom3_data,
    output logic [7:0] rom_addr,
    output logic [1:0] chan,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       wrap
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]     LAST0      = 8'(LEN0 - 1);
    localparam logic [7:0]     LAST1      = 8'(LEN1 - 1);
    localparam logic [7:0]     LAST2      = 8'(LEN2 - 1);
    localparam logic [7:0]     LAST3      = 8'(LEN3 - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    pend_q, pend_d;
    logic [7:0]    rom_addr_q, rom_addr_d;
    logic [1:0]    chan_q, chan_d;
    logic [7:0]    sample_q, sample_d;
    logic          sample_valid_q, sample_valid_d;

    logic [3:0]    grant_s;
    logic [3:0]    arb_grant_s;
    logic          arb_none_s;
    logic [3:0]    cand_s;
    logic          tick_s;
    logic          at_last_s;
    logic          wrap_s;
    logic [7:0]    rom_sel_s;
    logic [7:0]    last_addr_s;

    rr_arbiter4 u_arb (
        .pend_i  (pend_q),
        .chan_i  (chan_q),
        .grant_o (arb_grant_s),
        .none_o  (arb_none_s)
    );

    // A tick coinciding with enable=0 is discarded so disabling never advances the table
    assign tick_s    = (state_q == ST_PLAY) && (presc_q == PRESC_LAST) && enable;
    assign at_last_s = (rom_addr_q == last_addr_s);
    assign wrap_s    = tick_s && at_last_s;
    assign cand_s    = pend_q | req;

    // ROM data and last table address for the granted channel
    always_comb begin
        case (chan_q)
            2'd0: begin
                rom_sel_s   = rom0_data;
                last_addr_s = LAST0;
            end
            2'd1: begin
                rom_sel_s   = rom1_data;
                last_addr_s = LAST1;
            end
            2'd2: begin
                rom_sel_s   = rom2_data;
                last_addr_s = LAST2;
            end
            default: begin
                rom_sel_s   = rom3_data;
                last_addr_s = LAST3;
            end
        endcase
    end

    // Next-state, address, channel and sample logic
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        rom_addr_d     = rom_addr_q;
        chan_d         = chan_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        grant_s        = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                presc_d    = '0;
                rom_addr_d = 8'd0;
                sample_d   = 8'd0;
                if (enable && (cand_s != 4'b0000)) begin
                    state_d = ST_PLAY;
                    chan_d  = lowest_idx(cand_s);
                    grant_s = idx_to_onehot(lowest_idx(cand_s));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    presc_d    = '0;
                    rom_addr_d = 8'd0;
                    sample_d   = 8'd0;
                end else if (tick_s) begin
                    presc_d        = '0;
                    sample_d       = req[chan_q] ? rom_sel_s : 8'd0;
                    sample_valid_d = 1'b1;
                    if (at_last_s) begin
                        rom_addr_d = 8'd0;
                        if (latch_mode && !arb_none_s) begin
                            chan_d  = onehot_to_idx(arb_grant_s);
                            grant_s = arb_grant_s;
                        end else if (req[chan_q]) begin
                            grant_s = idx_to_onehot(chan_q);
                        end else if (!latch_mode && (req != 4'b0000)) begin
                            chan_d  = lowest_idx(req);
                            grant_s = idx_to_onehot(lowest_idx(req));
                        end else begin
                            // Idle outputs stay zero, so the closing sample is not presented
                            state_d        = ST_IDLE;
                            sample_d       = 8'd0;
                            sample_valid_d = 1'b0;
                        end
                    end else begin
                        rom_addr_d = rom_addr_q + 8'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                presc_d    = '0;
                rom_addr_d = 8'd0;
                sample_d   = 8'd0;
            end
        endcase
    end

    assign pend_d = (pend_q & ~grant_s) | req;

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            presc_q        <= '0;
            pend_q         <= 4'b0000;
            rom_addr_q     <= 8'd0;
            chan_q         <= 2'd0;
            sample_q       <= 8'd0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            pend_q         <= pend_d;
            rom_addr_q     <= rom_addr_d;
            chan_q         <= chan_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign chan         = chan_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign wrap         = wrap_s;

endmodule
